// File: rtl/mult_issue_queue.sv
// Tagged request FIFO and one-at-a-time sequencer in front of an iterative unsigned
// 32x32 multiplier. It adds sign/magnitude fix-up and a completion timeout.
module mult_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_valid_in,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_valid_out,
  input  logic [63:0]      mul_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sgn;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  req_t              head;
  logic [31:0]       head_mag_a;
  logic [31:0]       head_mag_b;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TAG_W-1:0]  cur_tag;
  logic              cur_neg;

  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign head     = mem[rd_ptr];

  // Two's complement negation of -2^31 yields 0x8000_0000, which is the correct magnitude.
  assign head_mag_a = (head.sgn && head.a[31]) ? (~head.a + 32'd1) : head.a;
  assign head_mag_b = (head.sgn && head.b[31]) ? (~head.b + 32'd1) : head.b;

  // NOTE: the storage array is deliberately not reset; count marks which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, sgn: in_signed, tag: in_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: every state register uses <= so all branches see this cycle's values, not partial updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      cur_tag      <= '0;
      cur_neg      <= 1'b0;
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      out_valid    <= 1'b0;
      out_r        <= '0;
      out_tag      <= '0;
      out_err      <= 1'b0;
    end else begin
      mul_valid_in <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            mul_valid_in <= 1'b1;
            mul_a        <= head_mag_a;
            mul_b        <= head_mag_b;
            cur_tag      <= head.tag;
            cur_neg      <= head.sgn && (head.a[31] ^ head.b[31]);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A done pulse on the last allowed cycle still wins over the timeout.
          if (mul_valid_out) begin
            out_valid <= 1'b1;
            out_r     <= cur_neg ? (~mul_r + 64'd1) : mul_r;
            out_tag   <= cur_tag;
            out_err   <= 1'b0;
            state     <= HOLD;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            out_valid <= 1'b1;
            out_r     <= '0;
            out_tag   <= cur_tag;
            out_err   <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    mul_valid_in |=> !mul_valid_in);

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_mult_issue_queue.sv
// Self-checking bench for mult_issue_queue: a latency-programmable multiplier model,
// a result scoreboard built from plain arithmetic, and directed plus random scenarios.
module tb_mult_issue_queue;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 4;
  localparam int MAX_WAIT = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic             in_signed = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             mul_valid_in;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_valid_out = 1'b0;
  logic [63:0]      mul_r = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  mult_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] r; logic [TAG_W-1:0] tag; logic err; } res_t;
  typedef struct { logic [31:0] a; logic [31:0] b; int lat; bit spur; } iss_t;

  res_t        exp_q[$];
  iss_t        iss_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          push_cyc = 0;
  int          issue_cyc = 0;
  int          issue_cnt = 0;
  int          done_cyc = 0;
  int          first_valid_cyc = 0;
  bit          spur_req = 1'b0;
  bit          tog_stop = 1'b0;

  // model-private state
  int          m_cd = 0;
  logic [63:0] m_prod = '0;
  bit          m_prev_iss = 1'b0;
  iss_t        m_e;
  bit          o_prev_ov = 1'b0;
  res_t        o_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic s);
    longint sa;
    if (!s) return a;
    sa = $signed(a);
    return 32'(sa < 0 ? -sa : sa);
  endfunction

  // Multiplier model: returns the product of the presented magnitudes 'lat' cycles after
  // the start pulse (lat 0 = never). Optionally fires a bogus done in the start cycle.
  initial begin : mul_model
    forever begin
      @(negedge clk);
      mul_valid_out = 1'b0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          mul_valid_out = 1'b1;
          mul_r         = m_prod;
          done_cyc      = cyc;
        end
      end
      if (spur_req) begin
        mul_valid_out = 1'b1;
        mul_r         = {$urandom, $urandom};
        spur_req      = 1'b0;
      end
      if (rst_n && mul_valid_in) begin
        checks++;
        if (m_prev_iss) begin
          errors++;
          $display("FAIL issue_pulse: mul_valid_in high 2 cycles in a row at cycle %0d, want 1-cycle pulse", cyc);
        end
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: start pulse at cycle %0d with a=%h b=%h, want no issue", cyc, mul_a, mul_b);
        end else begin
          m_e = iss_q.pop_front();
          if (mul_a !== m_e.a || mul_b !== m_e.b) begin
            errors++;
            $display("FAIL issue_operands: got mul_a=%h mul_b=%h, want mul_a=%h mul_b=%h", mul_a, mul_b, m_e.a, m_e.b);
          end
          m_prod = {32'b0, mul_a} * {32'b0, mul_b};
          m_cd   = m_e.lat;
          if (m_e.spur) begin
            mul_valid_out = 1'b1;
            mul_r         = ~m_prod;
          end
        end
        issue_cyc = cyc;
        issue_cnt++;
      end
      m_prev_iss = rst_n && mul_valid_in;
    end
  end

  // Output scoreboard: every accepted result must match the oldest outstanding request.
  initial begin : out_mon
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!o_prev_ov) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid at cycle %0d r=%h tag=%0d err=%b, want no result", cyc, out_r, out_tag, out_err);
        end else if (out_ready) begin
          o_e = exp_q.pop_front();
          checks++;
          if (out_r !== o_e.r || out_tag !== o_e.tag || out_err !== o_e.err) begin
            errors++;
            $display("FAIL result: got r=%h tag=%0d err=%b, want r=%h tag=%0d err=%b",
                     out_r, out_tag, out_err, o_e.r, o_e.tag, o_e.err);
          end
        end
      end
      o_prev_ov = rst_n && out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is taken.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [TAG_W-1:0] tag, input int lat, input bit spur);
    int   n;
    res_t r;
    iss_t i;
    n = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d not accepted in %0d cycles, want acceptance", tag, n);
    end else begin
      push_cyc = cyc;
      i.a    = ref_mag(a, s);
      i.b    = ref_mag(b, s);
      i.lat  = lat;
      i.spur = spur;
      iss_q.push_back(i);
      r.tag = tag;
      r.err = (lat == 0 || lat > MAX_WAIT);
      r.r   = r.err ? 64'd0 : ref_prod(a, b, s);
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results %0d issues outstanding, want 0", name, exp_q.size(), iss_q.size());
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (mul_valid_in !== 1'b0) begin errors++; $display("FAIL reset_mul_valid_in: got %b want 0", mul_valid_in); end
    checks++; if (mul_a !== 32'd0)       begin errors++; $display("FAIL reset_mul_a: got %h want 0", mul_a); end
    checks++; if (mul_b !== 32'd0)       begin errors++; $display("FAIL reset_mul_b: got %h want 0", mul_b); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_r !== 64'd0)       begin errors++; $display("FAIL reset_out_r: got %h want 0", out_r); end
    checks++; if (out_tag !== '0)        begin errors++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    checks++; if (out_err !== 1'b0)      begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    int base;
    base = issue_cnt;
    out_ready = 1'b1;
    send(32'd6, 32'd7, 1'b0, 4'd3, 8, 1'b0);
    wait_drain("unsigned");
    checks++;
    if (issue_cnt - base != 1) begin
      errors++; $display("FAIL unsigned_issue_count: got %0d pulses want 1", issue_cnt - base);
    end
    checks++;
    if (issue_cyc != push_cyc + 2) begin
      errors++; $display("FAIL unsigned_issue_latency: got %0d cycles want 2", issue_cyc - push_cyc);
    end
    checks++;
    if (first_valid_cyc != done_cyc + 1) begin
      errors++; $display("FAIL unsigned_out_latency: got %0d cycles after done want 1", first_valid_cyc - done_cyc);
    end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    send(32'hFFFF_FFFE, 32'd5, 1'b1, 4'd5, 3, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd6, 5, 1'b0);
    send(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 4'd7, 2, 1'b0);
    send(32'hFFFF_FFFE, 32'd5, 1'b0, 4'd8, 4, 1'b0);
    wait_drain("signed");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) send($urandom_range(1, 1000), $urandom_range(1, 1000), 1'b0, TAG_W'(t), 2, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a = 32'd99;
    in_b = 32'd99;
    in_signed = 1'b0;
    in_tag = 4'd9;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL full_in_ready: got %b want 0 (4 queued, 1 held)", in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("back_to_back");
    repeat (10) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    out_ready = 1'b1;
    send(32'd3, 32'd4, 1'b0, 4'd7, 0, 1'b0);
    wait_drain("timeout");
    checks++;
    if (first_valid_cyc != issue_cyc + MAX_WAIT + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles after issue want %0d", first_valid_cyc - issue_cyc, MAX_WAIT + 1);
    end
    send(32'd9, 32'd9, 1'b0, 4'd8, 4, 1'b0);
    wait_drain("after_timeout");
    send(32'd11, 32'hFFFF_FFF3, 1'b1, 4'd9, MAX_WAIT, 1'b0);
    wait_drain("edge_done");
    checks++;
    if (first_valid_cyc != issue_cyc + MAX_WAIT + 1) begin
      errors++; $display("FAIL edge_done_latency: got %0d cycles after issue want %0d", first_valid_cyc - issue_cyc, MAX_WAIT + 1);
    end
    send(32'd2, 32'd3, 1'b0, 4'd10, MAX_WAIT + 1, 1'b0);
    wait_drain("late_done");
  endtask

  task automatic test_spurious();
    int base;
    base = issue_cnt;
    out_ready = 1'b1;
    spur_req = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || issue_cnt != base) begin
      errors++; $display("FAIL idle_done: got out_valid=%b issues=%0d want 0 and 0", out_valid, issue_cnt - base);
    end
    send(32'd12, 32'd12, 1'b0, 4'd11, 5, 1'b1);
    wait_drain("issue_cycle_done");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int          k, lat;
    tog_stop = 1'b0;
    fork
      begin
        while (!tog_stop) begin
          @(posedge clk);
          #1;
          if (!tog_stop) out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      k = $urandom_range(0, 9);
      lat = (k == 0) ? 0 : (k == 1) ? MAX_WAIT + 1 : int'($urandom_range(1, MAX_WAIT));
      send(a, b, 1'($urandom_range(0, 1)), TAG_W'(i), lat, ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    tog_stop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_reset_mid();
    int base, n;
    out_ready = 1'b1;
    base = issue_cnt;
    send(32'd5, 32'd6, 1'b0, 4'd1, 10, 1'b0);
    send(32'd7, 32'd8, 1'b0, 4'd2, 3, 1'b0);
    n = 0;
    while (issue_cnt == base && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    iss_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got out_valid=%b in_ready=%b mul_valid_in=%b want 0 1 0", out_valid, in_ready, mul_valid_in);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = issue_cnt;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (issue_cnt != base || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got issues=%0d out_valid=%b want 0 and 0", issue_cnt - base, out_valid);
    end
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd4, 6, 1'b0);
    wait_drain("after_reset");
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
